fetch_sequencer: RTL

- Owns the program counter and sequences instruction fetch over a single-outstanding request/ready handshake to instruction memory.
- Presents each fetched instruction to decode and accepts the decoded next-PC selection in return.
- Applies sequential, branch, jump and register redirects, optionally honouring one MIPS branch delay slot.
- Sits between instruction memory and the decode/control stage of the CPU.

---
 rtl/npc_pkg.sv | 15 +
 rtl/npc_target.sv | 42 ++++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared encodings for the fetch sequencer: next-PC select codes and FSM states.
package npc_pkg;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JMP    = 2'b10;
    localparam logic [1:0] NPC_REG    = 2'b11;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        ISSUE = 2'b10
    } state_t;

endpackage

// File: rtl/npc_target.sv
// Combinational redirect decode: whether the issued instruction redirects, and where.
module npc_target
    import npc_pkg::*;
(
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [31:0] pc4,
    input  logic [15:0] imm,
    input  logic [25:0] j_addr,
    input  logic [31:0] reg_target,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] br_off;

    assign br_off = {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = pc4;
        case (npc_sel)
            NPC_BRANCH: begin
                taken  = branch_taken;
                target = pc4 + br_off;
            end
            NPC_JMP: begin
                taken  = 1'b1;
                target = {pc4[31:28], j_addr, 2'b00};
            end
            NPC_REG: begin
                taken  = 1'b1;
                target = reg_target & 32'hFFFF_FFFC;
            end
            default: begin
                taken  = 1'b0;
                target = pc4;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: single-outstanding instruction fetch, issue to decode,
// and sequential/branch/jump/register redirects with an optional delay slot.
module fetch_sequencer
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc4,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm,
    input  logic [25:0] j_addr,
    input  logic [31:0] reg_target,
    output logic        pend_valid
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;

    logic        taken;
    logic [31:0] target;

    assign pc4 = inst_pc_q + 32'd4;

    npc_target u_npc_target (
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .pc4          (pc4),
        .imm          (imm),
        .j_addr       (j_addr),
        .reg_target   (reg_target),
        .taken        (taken),
        .target       (target)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (DELAY_SLOT != 0) begin
                        // The slot instruction's own redirect is dropped when one is already pending.
                        if (pend_valid_q) begin
                            pc_d         = pend_target_q;
                            pend_valid_d = 1'b0;
                        end else if (taken) begin
                            pend_target_d = target;
                            pend_valid_d  = 1'b1;
                            pc_d          = pc4;
                        end else begin
                            pc_d = pc4;
                        end
                    end else begin
                        pc_d = taken ? target : pc4;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
        imem_req_d   = (state_d == FETCH);
        inst_valid_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            inst_q        <= 32'h0;
            inst_pc_q     <= 32'h0;
            imem_req_q    <= 1'b0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            imem_req_q    <= imem_req_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pend_valid = pend_valid_q;

endmodule
